// File: rtl/uart_rx_fifo.sv
// Purpose : 8N1 UART receiver with start-bit glitch filter, feeding a byte FIFO read through a 32-bit port.
// Latency : a byte is visible on rd_data_o the cycle after its mid-stop-bit sample (~SYNC_STAGES+HALF+9*DIV+1 from the pin edge).
// Backpr. : none toward the line; a byte arriving while the FIFO is full (no pop that cycle) is dropped and overflow_o latches.
//
// Ports:
//   clk_i, rst_i   system clock (rising edge) and asynchronous active-high reset
//   uart_rx_i      serial line, idle high, asynchronous to clk_i
//   rd_en_i        pop the head when the FIFO is non-empty
//   rd_data_o      {24'h0, head} or 32'hFFFF_FFFF when empty (combinational from the head)
//   count_o        FIFO occupancy
//   overflow_o     sticky: a byte was dropped on a full FIFO
//   frame_err_o    sticky: a stop bit was sampled low
//   clr_err_i      clears both sticky flags (a same-cycle set wins)
module uart_rx_fifo #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          uart_rx_i,
  input  logic                          rd_en_i,
  output logic [31:0]                   rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o,
  output logic                          frame_err_o,
  input  logic                          clr_err_i
);

  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int BW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;

  localparam logic [BW-1:0] BAUD_FULL = BW'(DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(HALF - 1);
  localparam logic [PW-1:0] DEPTH_CNT = PW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Line synchroniser. Reset to all ones so the idle-high line never looks
  // like a start bit as reset is released.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // RX state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [15:0]     bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push;
  logic            ferr_set;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          baud_d  = BAUD_HALF;
          state_d = S_START;
        end
      end

      // Mid-start-bit recheck: a low pulse shorter than half a bit is a glitch.
      S_START: begin
        if (baud_q != '0) begin
          baud_d = baud_q - BW'(1);
        end else if (!rxs) begin
          baud_d  = BAUD_FULL;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end

      // LSB arrives first, so shifting in at the MSB leaves bit 0 at [0] after 8 bits.
      S_DATA: begin
        if (baud_q != '0) begin
          baud_d = baud_q - BW'(1);
        end else begin
          shift_d = {rxs, shift_q[7:1]};
          baud_d  = BAUD_FULL;
          bit_d   = bit_q + 16'd1;
          if (bit_q == 16'd7) begin
            state_d = S_STOP;
          end
        end
      end

      // Returning to IDLE at mid-stop-bit leaves half a bit to catch the next start edge.
      S_STOP: begin
        if (baud_q != '0) begin
          baud_d = baud_q - BW'(1);
        end else if (rxs) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = S_WAIT_HIGH;
        end
      end

      // Hold off through a break so it reports a single framing error.
      S_WAIT_HIGH: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO: flop array, combinational head, pointers one bit wider than the
  // index so full and empty are distinguished by the occupancy difference.
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic          empty, full;
  logic          pop, wr_en, ovf_set;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  assign pop     = rd_en_i && !empty;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);

    // Set takes priority over a same-cycle clear.
    if (ovf_set)        overflow_d = 1'b1;
    else if (clr_err_i) overflow_d = 1'b0;

    if (ferr_set)       frame_err_d = 1'b1;
    else if (clr_err_i) frame_err_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage needs no reset: occupancy comes from the pointers alone.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  assign rd_data_o   = empty ? 32'hFFFF_FFFF : {24'h0, mem_q[rd_ptr_q[AW-1:0]]};
  assign count_o     = count;
  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DIV   = 10;   // 1 MHz / 100 kbaud
  localparam int DEPTH = 16;

  logic        clk_i     = 1'b0;
  logic        rst_i     = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic        rd_en_i   = 1'b0;
  logic        clr_err_i = 1'b0;
  logic [31:0] rd_data_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic        frame_err_o;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes the line has delivered and not yet consumed,
  // plus the flags the line history should have raised.
  logic [7:0] mq [$];
  logic       exp_ovf  = 1'b0;
  logic       exp_ferr = 1'b0;
  logic [7:0] mon_exp;
  bit         send_done;

  uart_rx_fifo #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .uart_rx_i  (uart_rx_i),
    .rd_en_i    (rd_en_i),
    .rd_data_o  (rd_data_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .frame_err_o(frame_err_o),
    .clr_err_i  (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop (rd_en_i high, data present) must match the
  // oldest byte the model says is queued.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i && rd_en_i && rd_data_o !== 32'hFFFF_FFFF) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no data", rd_data_o);
        end else begin
          mon_exp = mq.pop_front();
          if (rd_data_o !== {24'h0, mon_exp}) begin
            errors++;
            $display("FAIL pop_data: got %0h expected %0h", rd_data_o, {24'h0, mon_exp});
          end
        end
      end
    end
  end

  // All line driving starts on a falling clock edge.
  task automatic bit_time(input logic v);
    uart_rx_i = v;
    repeat (DIV) @(negedge clk_i);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() >= DEPTH) exp_ovf = 1'b1;
    else                    mq.push_back(b);
  endtask

  // low_stop = 0 sends a good frame; otherwise the stop bit is held low that many bit times.
  task automatic send(input logic [7:0] b, input int low_stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    if (low_stop == 0) begin
      model_push(b);
      bit_time(1'b1);
    end else begin
      exp_ferr = 1'b1;
      repeat (low_stop) bit_time(1'b0);
      bit_time(1'b1);
    end
  endtask

  task automatic drain(input string name);
    rd_en_i = 1'b1;
    repeat (20) @(negedge clk_i);
    rd_en_i = 1'b0;
    @(negedge clk_i);
    check({name, "_model_empty"}, 32'(mq.size()), 32'd0);
    check({name, "_count_zero"}, 32'(count_o), 32'd0);
  endtask

  task automatic clear_flags();
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    exp_ovf   = 1'b0;
    exp_ferr  = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic check_flags(input string name);
    check({name, "_overflow"}, 32'(overflow_o), 32'(exp_ovf));
    check({name, "_frame_err"}, 32'(frame_err_o), 32'(exp_ferr));
  endtask

  initial begin
    logic [7:0] burst [5];
    burst = '{8'h63, 8'h65, 8'h72, 8'h65, 8'h73};

    // Reset state
    repeat (5) @(negedge clk_i);
    check("reset_rd_data", rd_data_o, 32'hFFFF_FFFF);
    check("reset_count", 32'(count_o), 32'd0);
    check_flags("reset");
    rst_i = 1'b0;
    repeat (2 * DIV) @(negedge clk_i);

    // Single byte, then a one-cycle pop
    send(8'hA5, 0);
    repeat (5) @(negedge clk_i);
    check("single_count", 32'(count_o), 32'd1);
    check("single_data", rd_data_o, 32'h0000_00A5);
    rd_en_i = 1'b1;
    @(negedge clk_i);
    rd_en_i = 1'b0;
    @(negedge clk_i);
    check("single_after_pop_data", rd_data_o, 32'hFFFF_FFFF);
    check("single_after_pop_count", 32'(count_o), 32'd0);

    // Back-to-back burst with the consumer always reading
    rd_en_i = 1'b1;
    for (int i = 0; i < 5; i++) send(burst[i], 0);
    repeat (2 * DIV) @(negedge clk_i);
    rd_en_i = 1'b0;
    @(negedge clk_i);
    check("burst_model_empty", 32'(mq.size()), 32'd0);
    check("burst_count", 32'(count_o), 32'd0);
    check_flags("burst");

    // Overflow: 17 bytes into a 16-entry FIFO
    for (int i = 0; i <= 16; i++) send(8'(i), 0);
    repeat (5) @(negedge clk_i);
    check("ovf_count", 32'(count_o), 32'd16);
    check("ovf_head", rd_data_o, 32'h0000_0000);
    check_flags("ovf");
    drain("ovf");
    clear_flags();
    check_flags("ovf_cleared");

    // Framing error followed by a good byte
    send(8'h3C, 2);
    bit_time(1'b1);
    bit_time(1'b1);
    send(8'h11, 0);
    repeat (5) @(negedge clk_i);
    check("ferr_count", 32'(count_o), 32'd1);
    check_flags("ferr");
    drain("ferr");
    clear_flags();
    check_flags("ferr_cleared");

    // Glitch shorter than half a bit, then a good byte
    uart_rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (2 * DIV) @(negedge clk_i);
    check("glitch_count", 32'(count_o), 32'd0);
    check_flags("glitch");
    send(8'h7E, 0);
    repeat (5) @(negedge clk_i);
    check("glitch_next_count", 32'(count_o), 32'd1);
    drain("glitch");

    // Reset in bit 4 of 0xF0 with two bytes queued
    send(8'hAA, 0);
    send(8'h0F, 0);
    repeat (5) @(negedge clk_i);
    check("rst_pre_count", 32'(count_o), 32'd2);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b0);
    uart_rx_i = 1'b1;
    repeat (DIV / 2) @(negedge clk_i);
    rst_i = 1'b1;
    mq.delete();
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (12 * DIV) @(negedge clk_i);
    check("rst_mid_count", 32'(count_o), 32'd0);
    check("rst_mid_data", rd_data_o, 32'hFFFF_FFFF);
    check_flags("rst_mid");
    send(8'h55, 0);
    repeat (5) @(negedge clk_i);
    check("rst_next_count", 32'(count_o), 32'd1);
    check("rst_next_data", rd_data_o, 32'h0000_0055);
    drain("rst_next");

    // Random bytes with random gaps against a randomly toggling reader
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(8'($urandom()), 0);
          repeat ($urandom_range(0, 2)) bit_time(1'b1);
        end
        send_done = 1'b1;
      end
      begin
        while (!send_done) begin
          rd_en_i = 1'($urandom_range(0, 1));
          @(negedge clk_i);
        end
      end
    join
    drain("random");
    check_flags("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
